// File: rtl/tsr_weight_pkg.sv
// Shared definitions for the weight-load path: controller state encoding
// and the padded beat count that the 64-to-16 unpacker also uses.
package tsr_weight_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // The unpacker always emits whole 64-bit words, i.e. groups of four
  // 16-bit weights, so a load is rounded up to a multiple of four beats.
  function automatic int padded_count(input int num_weights);
    return ((num_weights + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// Weight-load controller: owns the single weight-memory port. While
// loading it forwards unpacker beats (dropping padding beats) and tracks
// ordering; once the load is complete it hands the port to the CNN
// compute read path.
//
// Handshake: ld_enable is a level that lets the unpacker pop its FIFO;
// every cycle with ld_wr_en=1 is one accepted beat (no back-pressure).
// cmp_rd_gnt is returned combinationally in the same cycle as
// cmp_rd_req and the memory read is issued in that same cycle.
module weight_load_ctrl
  import tsr_weight_pkg::*;
#(
  parameter int NUM_WEIGHTS = 56690,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             ld_enable,
  input  logic             ld_wr_en,
  input  logic [31:0]      ld_wr_addr,
  input  logic [15:0]      ld_wr_data,
  input  logic             cmp_rd_req,
  input  logic [31:0]      cmp_rd_addr,
  output logic             cmp_rd_gnt,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             busy,
  output logic             load_done,
  output logic             err,
  output logic [CNT_W-1:0] wr_count,
  output logic [1:0]       state_dbg
);

  localparam int               PADDED    = padded_count(NUM_WEIGHTS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PADDED - 1);
  localparam logic [31:0]      NUM_W32   = 32'(NUM_WEIGHTS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_nxt;
  logic             err_q, err_nxt;
  logic             done_q, done_nxt;

  assign wr_count  = wr_cnt_q;
  assign err       = err_q;
  assign load_done = done_q;
  assign state_dbg = state;

  // State and counter registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      wr_cnt_q <= wr_cnt_nxt;
      err_q    <= err_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next state, counters and the combinational memory-port mux. Write and
  // read paths live in different states, so they can never collide.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    wr_cnt_nxt   = wr_cnt_q;
    err_nxt      = err_q;
    done_nxt     = done_q;
    ld_enable    = 1'b0;
    busy         = 1'b0;
    cmp_rd_gnt   = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state)
      ST_IDLE: begin
        // A stray beat is flagged and dropped; a start clears the flag
        // unless a stray beat arrives in the very same cycle.
        if (ld_wr_en) err_nxt = 1'b1;
        if (start) begin
          state_nxt    = ST_LOAD;
          beat_cnt_nxt = '0;
          wr_cnt_nxt   = '0;
          err_nxt      = ld_wr_en;
        end
      end

      ST_LOAD: begin
        ld_enable = 1'b1;
        busy      = 1'b1;
        if (ld_wr_en) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          // Out-of-order beats are flagged but still written.
          if (ld_wr_addr != 32'(beat_cnt)) err_nxt = 1'b1;
          if (ld_wr_addr < NUM_W32) begin
            wr_cnt_nxt = wr_cnt_q + 1'b1;
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = ld_wr_addr;
            mem_wdata  = ld_wr_data;
          end
        end
        if (abort) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b0;
        end else if (ld_wr_en && (beat_cnt == LAST_BEAT)) begin
          state_nxt = ST_READY;
          done_nxt  = 1'b1;
        end
      end

      ST_READY: begin
        if (ld_wr_en) err_nxt = 1'b1;
        if (start) begin
          // Reload: the port belongs to the write path from now on.
          state_nxt    = ST_LOAD;
          beat_cnt_nxt = '0;
          wr_cnt_nxt   = '0;
          err_nxt      = ld_wr_en;
          done_nxt     = 1'b0;
        end else if (cmp_rd_req) begin
          cmp_rd_gnt = 1'b1;
          mem_en     = 1'b1;
          mem_addr   = cmp_rd_addr;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
